// File: rtl/apb_req_arbiter.sv
// Two-client round-robin APB master for the 16-slot register block at 0x0000-0x03C0.
// Define APB_TIMEOUT_EN to bound ACCESS to TIMEOUT cycles and return an error on expiry.
module apb_req_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic [DATA_W-1:0]             rdata,
    output logic                          PSELx,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_W-1:0]             PADDR,
    output logic [DATA_W-1:0]             PWDATA,
    output logic [DATA_W/8-1:0]           PSTRB,
    input  logic                          PREADY,
    input  logic [DATA_W-1:0]             PRDATA
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(32'h03C0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                cur_q, cur_d;
    logic                psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0]   paddr_d;
    logic [DATA_W-1:0]   pwdata_d, rdata_d;
    logic [STRB_W-1:0]   pstrb_d;
    logic [NUM_REQ-1:0]  done_d, err_d;

    logic [1:0]          elig;
    logic                win;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_write;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_strb;
    logic                sel_valid;
    logic                to_hit;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign to_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign to_hit = 1'b0;
`endif

    // Round-robin pick; a client completing this cycle is not eligible again yet.
    always_comb begin
        elig = req[1:0] & ~done[1:0];
        win  = 1'b0;
        if (elig[0] && elig[1]) begin
            win = ~last_q;
        end else if (elig[1]) begin
            win = 1'b1;
        end
        sel_addr  = win ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
        sel_write = win ? req_write[1]                 : req_write[0];
        sel_wdata = win ? req_wdata[DATA_W +: DATA_W]  : req_wdata[0 +: DATA_W];
        sel_strb  = win ? req_strb[STRB_W +: STRB_W]   : req_strb[0 +: STRB_W];
        sel_valid = (sel_addr[5:0] == 6'd0) && (sel_addr <= LAST_SLOT);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cur_d     = cur_q;
        psel_d    = PSELx;
        penable_d = PENABLE;
        pwrite_d  = PWRITE;
        paddr_d   = PADDR;
        pwdata_d  = PWDATA;
        pstrb_d   = PSTRB;
        done_d    = '0;
        err_d     = '0;
        rdata_d   = rdata;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    last_d = win;
                    if (sel_valid) begin
                        cur_d     = win;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = sel_addr;
                        pwrite_d  = sel_write;
                        pwdata_d  = sel_wdata;
                        pstrb_d   = sel_write ? sel_strb : '0;
                        state_d   = SETUP;
`ifdef APB_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end else begin
                        done_d[win] = 1'b1;
                        err_d[win]  = 1'b1;
                        rdata_d     = '0;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    done_d[cur_q] = 1'b1;
                    rdata_d       = PWRITE ? '0 : PRDATA;
                    state_d       = IDLE;
                end else if (to_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    done_d[cur_q] = 1'b1;
                    err_d[cur_q]  = 1'b1;
                    rdata_d       = '0;
                    state_d       = IDLE;
                end else begin
`ifdef APB_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cur_q   <= 1'b0;
            PSELx   <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            done    <= '0;
            err     <= '0;
            rdata   <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            PSELx   <= psel_d;
            PENABLE <= penable_d;
            PWRITE  <= pwrite_d;
            PADDR   <= paddr_d;
            PWDATA  <= pwdata_d;
            PSTRB   <= pstrb_d;
            done    <= done_d;
            err     <= err_d;
            rdata   <= rdata_d;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: directed scenarios plus randomized two-client traffic
// against a slot-memory reference model; clients use disjoint slots so order does not matter.
module tb_apb_req_arbiter;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic                PCLK = 1'b0;
    logic                PRESETn = 1'b0;
    logic [1:0]          req;
    logic [2*ADDR_W-1:0] req_addr;
    logic [1:0]          req_write;
    logic [2*DATA_W-1:0] req_wdata;
    logic [2*STRB_W-1:0] req_strb;
    logic [1:0]          done, err;
    logic [DATA_W-1:0]   rdata;
    logic                PSELx, PENABLE, PWRITE;
    logic [ADDR_W-1:0]   PADDR;
    logic [DATA_W-1:0]   PWDATA;
    logic [STRB_W-1:0]   PSTRB;
    logic                PREADY;
    logic [DATA_W-1:0]   PRDATA;

    logic                creq   [2];
    logic [ADDR_W-1:0]   caddr  [2];
    logic                cwrite [2];
    logic [DATA_W-1:0]   cwdata [2];
    logic [STRB_W-1:0]   cstrb  [2];

    assign req       = {creq[1], creq[0]};
    assign req_addr  = {caddr[1], caddr[0]};
    assign req_write = {cwrite[1], cwrite[0]};
    assign req_wdata = {cwdata[1], cwdata[0]};
    assign req_strb  = {cstrb[1], cstrb[0]};

    apb_req_arbiter #(.NUM_REQ(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strb(req_strb), .done(done), .err(err), .rdata(rdata),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int failures = 0;

    exp_t            sb0[$], sb1[$];
    int              done_log[$];
    int              done_total = 0;
    logic [31:0]     model_mem [16];
    logic [31:0]     slave_mem [16];
    int              slave_waits = 0;
    bit              slave_hang = 0;
    int              waits_left = 0;
    bit              psel_seen = 0;
    logic [ADDR_W-1:0] last_paddr;
    logic [STRB_W-1:0] last_pstrb;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic bit valid_addr(input logic [ADDR_W-1:0] a);
        return (a[5:0] == 6'd0) && (a <= 16'h03C0);
    endfunction

    // Reference model: outcome of a request computed from the address map and slot contents.
    task automatic expect_push(input int c, input logic [ADDR_W-1:0] a, input logic w,
                               input logic [31:0] d, input logic [3:0] s, input bit timeout);
        exp_t e;
        e.err   = 1'b0;
        e.rdata = '0;
        if (!valid_addr(a) || timeout) begin
            e.err = 1'b1;
        end else if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[a[9:6]][8*b +: 8] = d[8*b +: 8];
        end else begin
            e.rdata = model_mem[a[9:6]];
        end
        if (c == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Drive one request (called at posedge+1), wait for its done, release after the done cycle.
    task automatic issue(input int c, input logic [ADDR_W-1:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s, input int explat, input bit timeout);
        int n;
        bit got;
        expect_push(c, a, w, d, s, timeout);
        caddr[c]  = a;
        cwrite[c] = w;
        cwdata[c] = d;
        cstrb[c]  = s;
        creq[c]   = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 200) begin
            @(posedge PCLK);
            n++;
            @(negedge PCLK);
            if (done[c]) got = 1;
        end
        chk($sformatf("c%0d_done_arrives", c), 64'(got), 64'(1));
        if (got && explat >= 0) chk($sformatf("c%0d_latency", c), 64'(n), 64'(explat));
        @(posedge PCLK);
        #1;
        creq[c] = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] region_addr(input int c);
        return ADDR_W'((c * 8 + int'($urandom_range(0, 7))) * 64);
    endfunction

    // Slave: completes writes into its slot memory, inserts wait states, can stall forever.
    initial begin
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(posedge PCLK);
            if (PRESETn && PSELx && PENABLE && PREADY && PWRITE)
                for (int b = 0; b < 4; b++)
                    if (PSTRB[b]) slave_mem[PADDR[9:6]][8*b +: 8] = PWDATA[8*b +: 8];
            #1;
            PREADY = 1'b0;
            PRDATA = $urandom;
            if (PSELx && !PENABLE) begin
                waits_left = (slave_waits < 0) ? int'($urandom_range(0, 3)) : slave_waits;
            end else if (PSELx && PENABLE && !slave_hang) begin
                if (waits_left == 0) begin
                    PREADY = 1'b1;
                    if (!PWRITE) PRDATA = slave_mem[PADDR[9:6]];
                end else begin
                    waits_left--;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a done pulse is presented.
    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (|err) chk("err_without_done", 64'(err & ~done), 64'(0));
            if (|done) chk("done_exclusive", 64'(done == 2'b11), 64'(0));
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    exp_t e;
                    done_total++;
                    done_log.push_back(i);
                    if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
                        checks++;
                        failures++;
                        $display("FAIL c%0d_unexpected_done: got done with no outstanding request", i);
                    end else begin
                        e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                        chk($sformatf("c%0d_err", i), 64'(err[i]), 64'(e.err));
                        chk($sformatf("c%0d_rdata", i), 64'(rdata), 64'(e.rdata));
                    end
                end
            end
        end
    end

    // Bus protocol monitor.
    bit          prev_setup = 0, prev_wait = 0, prev_xfer = 0;
    logic [63:0] prev_payload = '0;
    always @(negedge PCLK) begin
        logic [63:0] payload;
        payload = 64'({PADDR, PWRITE, PWDATA, PSTRB});
        if (!PRESETn) begin
            prev_setup = 0;
            prev_wait  = 0;
            prev_xfer  = 0;
        end else begin
            if (PENABLE) chk("penable_without_psel", 64'(PSELx), 64'(1));
            if (PSELx && !PWRITE) chk("pstrb_on_read", 64'(PSTRB), 64'(0));
            if (prev_setup) begin
                chk("setup_to_access", 64'({PSELx, PENABLE}), 64'(2'b11));
                chk("setup_payload_stable", payload, prev_payload);
            end
            if (prev_wait) begin
                if (PSELx) begin
                    chk("wait_penable_held", 64'(PENABLE), 64'(1));
                    chk("wait_payload_stable", payload, prev_payload);
                end else begin
                    chk("release_only_on_timeout", 64'({|done, |err}), 64'(2'b11));
                end
            end
            if (prev_xfer) chk("psel_gap_after_transfer", 64'(PSELx), 64'(0));
            if (PSELx) psel_seen = 1;
            if (PSELx && PENABLE && PREADY) begin
                last_paddr = PADDR;
                last_pstrb = PSTRB;
            end
            prev_setup   = PSELx && !PENABLE;
            prev_wait    = PSELx && PENABLE && !PREADY;
            prev_xfer    = PSELx && PENABLE && PREADY;
            prev_payload = payload;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        bit got;
        for (int i = 0; i < 2; i++) begin
            creq[i] = 1'b0; caddr[i] = '0; cwrite[i] = 1'b0; cwdata[i] = '0; cstrb[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = '0;
            slave_mem[i] = '0;
        end
        model_mem[15] = 32'h1234_5678;
        slave_mem[15] = 32'h1234_5678;

        // Reset state.
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel", 64'(PSELx), 64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_payload", 64'({PADDR, PWRITE, PWDATA, PSTRB}), 64'(0));
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        // Single write with two wait states.
        slave_waits = 2;
        issue(0, 16'h0040, 1'b1, 32'hA5A5_5A5A, 4'hF, 5, 0);
        chk("wr_pstrb", 64'(last_pstrb), 64'(4'hF));
        chk("wr_paddr", 64'(last_paddr), 64'(16'h0040));

        // Read from the top slot, zero wait.
        slave_waits = 0;
        issue(1, 16'h03C0, 1'b0, 32'hDEAD_BEEF, 4'hF, 3, 0);
        chk("rd_pstrb", 64'(last_pstrb), 64'(0));

        // Contention: both clients back-to-back.
        done_log.delete();
        fork
            for (int k = 0; k < 4; k++)
                issue(0, region_addr(0), 1'($urandom), $urandom, 4'($urandom), -1, 0);
            for (int k = 0; k < 4; k++)
                issue(1, region_addr(1), 1'($urandom), $urandom, 4'($urandom), -1, 0);
        join
        chk("rr_count", 64'(done_log.size()), 64'(8));
        for (int k = 0; k < done_log.size() && k < 8; k++)
            chk($sformatf("rr_order_%0d", k), 64'(done_log[k]), 64'(k % 2));

        // Address rejection.
        psel_seen = 0;
        issue(0, 16'h0044, 1'b1, 32'h1111_2222, 4'hF, 1, 0);
        issue(0, 16'h0400, 1'b0, 32'h0, 4'h0, 1, 0);
        chk("reject_no_psel", 64'(psel_seen), 64'(0));

        // Reset in the middle of ACCESS.
        slave_hang = 1;
        caddr[0] = 16'h0080; cwrite[0] = 1'b0; cwdata[0] = '0; cstrb[0] = '0;
        creq[0] = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PENABLE && n < 10);
        chk("mid_reached_access", 64'(PENABLE), 64'(1));
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_psel", 64'(PSELx), 64'(0));
        chk("mid_rst_penable", 64'(PENABLE), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        creq[0] = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        d0 = done_total;
        repeat (6) @(posedge PCLK);
        #1;
        chk("mid_no_done_after", 64'(done_total), 64'(d0));
        slave_hang = 0;
        issue(0, 16'h0080, 1'b0, 32'h0, 4'h0, 3, 0);

        // Slave that never answers.
        slave_hang = 1;
`ifdef APB_TIMEOUT_EN
        issue(0, 16'h00C0, 1'b1, $urandom, 4'hF, TIMEOUT + 2, 1);
        chk("to_bus_released", 64'({PSELx, PENABLE}), 64'(0));
        slave_hang = 0;
`else
        expect_push(0, 16'h00C0, 1'b1, 32'hCAFE_F00D, 4'hF, 0);
        caddr[0] = 16'h00C0; cwrite[0] = 1'b1; cwdata[0] = 32'hCAFE_F00D; cstrb[0] = 4'hF;
        creq[0] = 1'b1;
        n = 0;
        repeat (102) begin
            @(negedge PCLK);
            if (PSELx && PENABLE) n++;
        end
        chk("hang_access_cycles", 64'(n), 64'(100));
        slave_hang = 0;
        got = 0;
        n = 0;
        while (!got && n < 10) begin
            @(negedge PCLK);
            n++;
            if (done[0]) got = 1;
        end
        chk("hang_done_after_release", 64'(got), 64'(1));
        @(posedge PCLK);
        #1;
        creq[0] = 1'b0;
`endif

        // Randomized traffic with random wait states and occasional bad addresses.
        slave_waits = -1;
        fork
            for (int k = 0; k < 30; k++) begin
                logic [ADDR_W-1:0] a;
                if ($urandom_range(0, 4) == 0) begin
                    a = ADDR_W'($urandom);
                    if (valid_addr(a)) a[0] = 1'b1;
                end else begin
                    a = region_addr(0);
                end
                issue(0, a, 1'($urandom), $urandom, 4'($urandom), -1, 0);
                repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
            end
            for (int k = 0; k < 30; k++) begin
                logic [ADDR_W-1:0] a;
                if ($urandom_range(0, 4) == 0) begin
                    a = ADDR_W'($urandom);
                    if (valid_addr(a)) a[0] = 1'b1;
                end else begin
                    a = region_addr(1);
                end
                issue(1, a, 1'($urandom), $urandom, 4'($urandom), -1, 0);
                repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
            end
        join

        repeat (3) @(posedge PCLK);
        #1;
        chk("sb0_drained", 64'(sb0.size()), 64'(0));
        chk("sb1_drained", 64'(sb1.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-requester APB master that shares a single APB slave port, the 16-slot register block at 0x0000–0x03C0 with a 0x40 stride, between two internal clients. It owns the complete APB protocol: round-robin grant, SETUP and ACCESS phases, PREADY wait and per-client completion. It also rejects out-of-map addresses before they reach the bus.

## Interface
- NUM_REQ, 2, number of requesters; fixed at 2 in this revision.
- ADDR_W, 16, APB address width.
- DATA_W, 32, APB data width; PSTRB width is DATA_W/8.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY. Used only when APB_TIMEOUT_EN is defined.
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous, active-low reset.
- req  in  2  per-client request; held high with stable payload until that client's done.
- req_addr  in  2*ADDR_W  per-client address; client i occupies bits [i*ADDR_W +: ADDR_W].
- req_write  in  2  1 = write, 0 = read.
- req_wdata  in  2*DATA_W  per-client write data.
- req_strb  in  2*DATA_W/8  per-client byte strobes; ignored on reads (PSTRB driven 0).
- done  out  2  one-cycle completion pulse per client.
- err  out  2  qualifies done: address rejected or timed out.
- rdata  out  DATA_W  read data, valid while any done bit is high.
- PSELx, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB strobes.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_W  slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- **IDLE**
  - Arbitrate among eligible requests. A client whose done is high in the current cycle is masked.
  - Round-robin pointer `last` resets to 1, so client 0 wins the first tie.
  - The winner becomes `last`.
  - Valid address: addr ∈ {0x0000, 0x0040, …, 0x03C0}, i.e. addr[5:0]==0 and addr ≤ 0x03C0.
    - Latch addr, write, wdata and strb onto the APB outputs.
    - Set PSELx=1, PENABLE=0 and go to SETUP.
  - Invalid address:
    - No bus activity.
    - done[i]=1, err[i]=1, rdata=0 next cycle; stay in IDLE.
- **SETUP**
  - Always exactly one cycle.
  - Set PENABLE=1 and go to ACCESS.
- **ACCESS**
  - Hold PSELx, PENABLE, PADDR, PWRITE, PWDATA and PSTRB stable.
  - On PREADY=1:
    - Next cycle: PSELx=0, PENABLE=0, done[i]=1, err[i]=0.
    - For a read, rdata is PRDATA captured at that edge; for a write, rdata=0.
    - Go to IDLE.
- Payload outputs (PADDR, PWDATA, PSTRB, PWRITE) keep their last values in IDLE. Only PSELx and PENABLE return to 0.
- rdata holds its last value when done=0.
- The two clients never receive done in the same cycle.

## Timing
- Reset values:
  - FSM = IDLE; all outputs 0.
  - Timeout counter = 0.
  - `last` = 1.
- Valid transfer, request seen at edge 0, PREADY high on the first ACCESS cycle:
  - PSELx high after edge 0 (SETUP).
  - PENABLE high after edge 1 (ACCESS).
  - PREADY sampled at edge 2.
  - done high after edge 2.
  - Minimum latency from request to done: 3 cycles.
- Each PREADY wait cycle adds one cycle of latency.
- Back-to-back transfers:
  - The next grant can be taken in the done cycle, from the other client only.
  - Minimum idle gap on PSELx: 1 cycle.
- Both clients requesting continuously: grants strictly alternate 0,1,0,1…
- Invalid address: done/err one cycle after the request is sampled.
- PRESETn asserted mid-transfer:
  - All outputs clear immediately (asynchronous).
  - No done is issued for the aborted transfer.
  - The client must re-request after reset.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter runs during ACCESS.
  - If PREADY is still low after TIMEOUT ACCESS cycles: next cycle PSELx=0, PENABLE=0, done[i]=1, err[i]=1, rdata=0, then IDLE.
  - The counter clears on entry to SETUP.
- APB_TIMEOUT_EN undefined:
  - No counter; ACCESS waits for PREADY indefinitely.
  - The TIMEOUT parameter is unused.

## Test plan
- Reset and single write: after reset, client 0 writes addr 0x0040, wdata 0xA5A5_5A5A, strb 0xF, slave PREADY after 2 wait cycles. Required: PSELx/PENABLE phases correct, PSTRB=0xF, done[0]=1 with err[0]=0 exactly 5 cycles after the request.
- Read: client 1 reads 0x03C0, slave returns PRDATA 0x1234_5678 on the first ACCESS cycle. Required: done[1]=1 and rdata=0x1234_5678 3 cycles after the request, PSTRB=0.
- Contention: both clients request continuously, 8 transfers, zero-wait slave. Required: grant order 0,1,0,1,…, and PSELx is never high in two consecutive transfers without a 1-cycle gap.
- Address rejection: client 0 requests 0x0044, then 0x0400. Required: done[0]=err[0]=1 one cycle after each request, PSELx stays 0 throughout.
- Reset mid-ACCESS: drop PRESETn while PENABLE=1. Required: PSELx, PENABLE and done are 0 immediately, no done after release, and a fresh request completes normally.
- APB_TIMEOUT_EN, TIMEOUT=16, slave holds PREADY=0. Required: after 16 ACCESS cycles, done[0]=err[0]=1 and the bus is released. With the macro undefined, the bus stays in ACCESS for at least 100 cycles.
